// File: rtl/tl_pkg.sv
// Shared lamp encodings, fault codes and monitor state for the traffic-light
// conflict monitor.
package tl_pkg;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

   localparam logic [2:0] CODE_NONE     = 3'd0;
   localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
   localparam logic [2:0] CODE_CROSS    = 3'd2;
   localparam logic [2:0] CODE_TURN     = 3'd3;
   localparam logic [2:0] CODE_SKIP_YEL = 3'd4;
   localparam logic [2:0] CODE_STUCK    = 3'd5;

   typedef enum logic [1:0] {
      ST_ARM,
      ST_RUN,
      ST_FAULT,
      ST_RECOVER
   } mon_state_t;

endpackage

// File: rtl/light_group_checker.sv
// Per-group lamp sanity flags: one-hot legality, non-red, and a green lamp
// that went straight to red since the previous cycle.
module light_group_checker (
   input  logic [2:0] cur,
   input  logic [2:0] prev,
   output logic       legal,
   output logic       non_red,
   output logic       green_to_red
);
   import tl_pkg::*;

   assign legal        = (cur == RED) || (cur == YEL) || (cur == GRN);
   assign non_red      = (cur != RED);
   assign green_to_red = (prev == GRN) && (cur == RED);

endmodule

// File: rtl/signal_conflict_monitor.sv
// Safety monitor sitting between the controller and the lamps: passes lamp
// commands through while they are safe, otherwise latches a fault and flashes red.
module signal_conflict_monitor #(
   parameter int STUCK_LIMIT    = 15,
   parameter int RECOVER_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] light_M1,
   input  logic [2:0] light_S,
   input  logic [2:0] light_MT,
   input  logic [2:0] light_M2,
   input  logic       clr_fault,
   output logic [2:0] out_M1,
   output logic [2:0] out_S,
   output logic [2:0] out_MT,
   output logic [2:0] out_M2,
   output logic       fault,
   output logic [2:0] fault_code
);
   import tl_pkg::*;

   localparam logic [3:0]  STUCK_MAX = 4'(STUCK_LIMIT);
   localparam logic [3:0]  CLEAN_MAX = 4'(RECOVER_CYCLES);
   localparam logic [11:0] ALL_RED   = {4{RED}};
   localparam logic [11:0] ALL_OFF   = {4{OFF}};

   mon_state_t  state, state_n;
   logic [11:0] cur_lights, prev_lights, out_lights, out_n;
   logic [3:0]  legal, non_red, green_to_red;
   logic [3:0]  stuck_cnt, stuck_n, stuck_inc;
   logic [3:0]  clean_cnt, clean_n, clean_inc;
   logic        flash_off, flash_n, fault_n, unchanged, trip;
   logic [2:0]  code_n, trip_code, safety_code, run_code;

   // Group order in the packed vectors: M1 [11:9], S [8:6], MT [5:3], M2 [2:0].
   assign cur_lights = {light_M1, light_S, light_MT, light_M2};

   for (genvar g = 0; g < 4; g++) begin : g_chk
      light_group_checker u_chk (
         .cur          (cur_lights[g*3 +: 3]),
         .prev         (prev_lights[g*3 +: 3]),
         .legal        (legal[g]),
         .non_red      (non_red[g]),
         .green_to_red (green_to_red[g])
      );
   end

   assign unchanged = (cur_lights == prev_lights);
   assign stuck_inc = (stuck_cnt == STUCK_MAX) ? stuck_cnt : stuck_cnt + 4'd1;
   assign clean_inc = clean_cnt + 4'd1;

   // Codes 1-3 apply in every checking state; the if-chain gives lowest-code priority.
   always_comb begin
      safety_code = CODE_NONE;
      if (legal != 4'hF)
         safety_code = CODE_ILLEGAL;
      else if (non_red[2] && (non_red[3] || non_red[1] || non_red[0]))
         safety_code = CODE_CROSS;
      else if (non_red[1] && non_red[0])
         safety_code = CODE_TURN;
   end

   always_comb begin
      run_code = safety_code;
      if (safety_code == CODE_NONE) begin
         if (|green_to_red)
            run_code = CODE_SKIP_YEL;
         else if (unchanged && (stuck_inc == STUCK_MAX))
            run_code = CODE_STUCK;
      end
   end

   // Any state that detects a violation raises trip; the common fault entry
   // at the bottom then overrides whatever that state would otherwise load.
   always_comb begin
      state_n   = state;
      out_n     = ALL_RED;
      fault_n   = fault;
      code_n    = fault_code;
      stuck_n   = '0;
      clean_n   = '0;
      flash_n   = 1'b0;
      trip      = 1'b0;
      trip_code = CODE_NONE;
      case (state)
         ST_ARM: begin
            trip      = (safety_code != CODE_NONE);
            trip_code = safety_code;
            state_n   = ST_RUN;
         end
         ST_RUN: begin
            trip      = (run_code != CODE_NONE);
            trip_code = run_code;
            out_n     = cur_lights;
            stuck_n   = unchanged ? stuck_inc : 4'd0;
         end
         ST_FAULT: begin
            out_n   = flash_off ? ALL_OFF : ALL_RED;
            flash_n = ~flash_off;
            if (clr_fault) begin
               state_n = ST_RECOVER;
               out_n   = ALL_RED;
               flash_n = 1'b0;
            end
         end
         ST_RECOVER: begin
            trip      = (safety_code != CODE_NONE);
            trip_code = safety_code;
            if (clean_inc == CLEAN_MAX) begin
               state_n = ST_RUN;
               fault_n = 1'b0;
               code_n  = CODE_NONE;
            end else begin
               clean_n = clean_inc;
            end
         end
         default: state_n = ST_ARM;
      endcase
      if (trip) begin
         state_n = ST_FAULT;
         out_n   = ALL_RED;
         fault_n = 1'b1;
         code_n  = trip_code;
         flash_n = 1'b1;
         stuck_n = '0;
         clean_n = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_ARM;
         out_lights  <= ALL_RED;
         fault       <= 1'b0;
         fault_code  <= CODE_NONE;
         stuck_cnt   <= '0;
         clean_cnt   <= '0;
         flash_off   <= 1'b0;
         prev_lights <= ALL_RED;
      end else begin
         state       <= state_n;
         out_lights  <= out_n;
         fault       <= fault_n;
         fault_code  <= code_n;
         stuck_cnt   <= stuck_n;
         clean_cnt   <= clean_n;
         flash_off   <= flash_n;
         prev_lights <= cur_lights;
      end
   end

   assign out_M1 = out_lights[11:9];
   assign out_S  = out_lights[8:6];
   assign out_MT = out_lights[5:3];
   assign out_M2 = out_lights[2:0];

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Scoreboard bench for signal_conflict_monitor: directed scenarios plus
// randomized controller traffic, checked against a behavioural model.
module tb_signal_conflict_monitor;

   localparam int STUCK = 15;
   localparam int RECOV = 4;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   localparam int MD_ARM     = 0;
   localparam int MD_RUN     = 1;
   localparam int MD_FAULT   = 2;
   localparam int MD_RECOVER = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] light_M1, light_S, light_MT, light_M2;
   logic       clr_fault;
   logic [2:0] out_M1, out_S, out_MT, out_M2;
   logic       fault;
   logic [2:0] fault_code;

   typedef struct packed {
      logic [11:0] lamps;
      logic        flt;
      logic [2:0]  code;
   } exp_t;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cycleNum   = 0;

   // Reference model: lamp index 0=M1, 1=S, 2=MT, 3=M2.
   int         mMode;
   bit         mBlink;
   int         mHeld;
   int         mClean;
   logic [2:0] mPrev[4];
   logic [2:0] mOut[4];
   logic       mFault;
   logic [2:0] mCode;

   signal_conflict_monitor #(
      .STUCK_LIMIT    (STUCK),
      .RECOVER_CYCLES (RECOV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .light_M1   (light_M1),
      .light_S    (light_S),
      .light_MT   (light_MT),
      .light_M2   (light_M2),
      .clr_fault  (clr_fault),
      .out_M1     (out_M1),
      .out_S      (out_S),
      .out_MT     (out_MT),
      .out_M2     (out_M2),
      .fault      (fault),
      .fault_code (fault_code)
   );

   always #5 clk = ~clk;

   function automatic bit isLamp(logic [2:0] v);
      return (v == R) || (v == Y) || (v == G);
   endfunction

   function automatic int safetyCode(logic [2:0] m1, logic [2:0] s, logic [2:0] mt, logic [2:0] m2);
      if (!isLamp(m1) || !isLamp(s) || !isLamp(mt) || !isLamp(m2)) return 1;
      if (s != R && (m1 != R || mt != R || m2 != R)) return 2;
      if (mt != R && m2 != R) return 3;
      return 0;
   endfunction

   // Six-phase controller cycle: 8,3,6,3,4,3 cycles; lamps packed {M1,S,MT,M2}.
   function automatic logic [11:0] ctrlPattern(int pos);
      if (pos < 8)       return {G, R, R, G};
      else if (pos < 11) return {G, R, R, Y};
      else if (pos < 17) return {G, R, G, R};
      else if (pos < 20) return {Y, R, Y, R};
      else if (pos < 24) return {R, G, R, R};
      else               return {R, Y, R, R};
   endfunction

   task automatic setAll(input logic [2:0] v);
      for (int i = 0; i < 4; i++) mOut[i] = v;
   endtask

   task automatic modelReset();
      mMode  = MD_ARM;
      mBlink = 1'b0;
      mHeld  = 0;
      mClean = 0;
      mFault = 1'b0;
      mCode  = 3'd0;
      for (int i = 0; i < 4; i++) begin
         mPrev[i] = R;
         mOut[i]  = R;
      end
   endtask

   task automatic goFault(input int v);
      mMode  = MD_FAULT;
      mFault = 1'b1;
      mCode  = 3'(v);
      mBlink = 1'b1;
      mClean = 0;
      mHeld  = 0;
      setAll(R);
   endtask

   task automatic modelStep(input logic [2:0] m1, input logic [2:0] s, input logic [2:0] mt,
                            input logic [2:0] m2, input logic clr);
      logic [2:0] cur[4];
      int         v;
      bit         same;
      cur[0] = m1; cur[1] = s; cur[2] = mt; cur[3] = m2;
      v = safetyCode(m1, s, mt, m2);
      case (mMode)
         MD_ARM: begin
            if (v != 0) goFault(v);
            else begin
               mMode = MD_RUN;
               setAll(R);
            end
         end
         MD_RUN: begin
            same = 1'b1;
            for (int i = 0; i < 4; i++) if (cur[i] != mPrev[i]) same = 1'b0;
            mHeld = same ? mHeld + 1 : 0;
            if (v == 0)
               for (int i = 0; i < 4; i++) if (mPrev[i] == G && cur[i] == R) v = 4;
            if (v == 0 && mHeld >= STUCK) v = 5;
            if (v != 0) goFault(v);
            else for (int i = 0; i < 4; i++) mOut[i] = cur[i];
         end
         MD_FAULT: begin
            setAll(mBlink ? 3'b000 : R);
            mBlink = !mBlink;
            if (clr) begin
               mMode = MD_RECOVER;
               setAll(R);
            end
         end
         default: begin
            if (v != 0) goFault(v);
            else begin
               setAll(R);
               mClean++;
               if (mClean == RECOV) begin
                  mMode  = MD_RUN;
                  mClean = 0;
                  mFault = 1'b0;
                  mCode  = 3'd0;
               end
            end
         end
      endcase
      for (int i = 0; i < 4; i++) mPrev[i] = cur[i];
   endtask

   // Called at a falling edge: drives inputs, queues the model's response for
   // the coming rising edge, then waits for the next falling edge.
   task automatic applyStimulus(input logic [2:0] m1, input logic [2:0] s, input logic [2:0] mt,
                                input logic [2:0] m2, input logic clr);
      exp_t e;
      light_M1  = m1;
      light_S   = s;
      light_MT  = mt;
      light_M2  = m2;
      clr_fault = clr;
      modelStep(m1, s, mt, m2, clr);
      e.lamps = {mOut[0], mOut[1], mOut[2], mOut[3]};
      e.flt   = mFault;
      e.code  = mCode;
      expQ.push_back(e);
      @(negedge clk);
   endtask

   task automatic applyPattern(input logic [11:0] p, input logic clr);
      applyStimulus(p[11:9], p[8:6], p[5:3], p[2:0], clr);
   endtask

   task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got %b, required %b", name, cycleNum, act, req);
      end
   endtask

   // Monitor: one queued expectation per rising edge, sampled 1 ns after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycleNum++;
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("lamps", {out_M1, out_S, out_MT, out_M2}, e.lamps);
            checkOutput("fault", {11'b0, fault}, {11'b0, e.flt});
            checkOutput("fault_code", {9'b0, fault_code}, {9'b0, e.code});
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [11:0] curPat;
      int          pos, hold, r, k;

      reset     = 1'b0;
      {light_M1, light_S, light_MT, light_M2} = ctrlPattern(0);
      clr_fault = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("reset lamps", {out_M1, out_S, out_MT, out_M2}, 12'b100100100100);
      checkOutput("reset fault", {11'b0, fault}, 12'd0);
      checkOutput("reset fault_code", {9'b0, fault_code}, 12'd0);

      $display("[TB] release reset, two full controller cycles");
      reset = 1'b1;
      for (int rep = 0; rep < 2; rep++)
         for (int p = 0; p < 27; p++) applyPattern(ctrlPattern(p), 1'b0);

      $display("[TB] cross conflict, flash, clear and recover");
      applyStimulus(G, G, R, R, 1'b0);
      repeat (3) applyStimulus(R, R, R, R, 1'b0);
      applyStimulus(R, R, R, R, 1'b1);
      repeat (RECOV) applyStimulus(R, R, R, R, 1'b0);

      $display("[TB] skipped yellow, then a later illegal lamp");
      repeat (3) applyPattern(ctrlPattern(0), 1'b0);
      applyStimulus(G, R, R, R, 1'b0);
      applyStimulus(G, R, R, R, 1'b0);
      applyStimulus(G, R, 3'b011, R, 1'b0);
      applyStimulus(R, R, R, R, 1'b1);
      repeat (RECOV) applyStimulus(R, R, R, R, 1'b0);

      $display("[TB] stuck inputs");
      repeat (20) applyPattern(ctrlPattern(0), 1'b0);

      $display("[TB] turn conflict during recovery");
      applyPattern(ctrlPattern(0), 1'b1);
      applyPattern(ctrlPattern(0), 1'b0);
      applyStimulus(R, R, G, G, 1'b0);
      repeat (3) applyStimulus(R, R, R, R, 1'b0);

      $display("[TB] asynchronous reset while faulted");
      reset = 1'b0;
      #1;
      checkOutput("async reset lamps", {out_M1, out_S, out_MT, out_M2}, 12'b100100100100);
      checkOutput("async reset fault", {11'b0, fault}, 12'd0);
      checkOutput("async reset fault_code", {9'b0, fault_code}, 12'd0);
      modelReset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int p = 0; p < 12; p++) applyPattern(ctrlPattern(p), 1'b0);

      $display("[TB] randomized traffic");
      pos    = 12;
      hold   = 0;
      curPat = ctrlPattern(pos);
      for (int n = 0; n < 1500; n++) begin
         r = int'($urandom_range(0, 99));
         if (hold > 0) begin
            hold--;
         end else if (r < 80) begin
            pos    = (pos + 1) % 27;
            curPat = ctrlPattern(pos);
         end else if (r < 90) begin
            curPat = ctrlPattern(pos);
            k      = int'($urandom_range(0, 3));
            curPat[3*k +: 3] = 3'($urandom_range(0, 7));
         end else if (r < 97) begin
            pos    = int'($urandom_range(0, 26));
            curPat = ctrlPattern(pos);
         end else begin
            hold = int'($urandom_range(10, 20));
         end
         applyPattern(curPat, ($urandom_range(0, 5) == 0));
      end

      @(posedge clk);
      #2;
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard drain: %0d entries left, required 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
